// File: rtl/eth_rst_pkg.sv
// Shared reset-sequencer definitions: FSM state encoding and counter sizing helpers.
// Used by eth_rst_seq and other sequencers that share the same phase layout.
package eth_rst_pkg;

  typedef enum logic [2:0] {
    WAIT_LOCK  = 3'd0,
    PHY_RST    = 3'd1,
    PHY_SETTLE = 3'd2,
    RELEASE    = 3'd3,
    RUN        = 3'd4
  } rst_state_e;

  // A programmed count of 0 behaves as 1 so every timed phase lasts at least one clock.
  function automatic int unsigned eff_cyc(input int unsigned cyc);
    return (cyc == 32'd0) ? 32'd1 : cyc;
  endfunction

  function automatic int unsigned max_cyc(input int unsigned a, input int unsigned b,
                                          input int unsigned c, input int unsigned d,
                                          input int unsigned e);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (e > m) m = e;
    return m;
  endfunction

  function automatic int cnt_width(input int unsigned max_count);
    return $clog2(eff_cyc(max_count)) + 1;
  endfunction

endpackage

// File: rtl/eth_rst_seq_lock_filt.sv
// PLL lock qualifier: 2-flop synchroniser followed by a saturating run-length filter.
// lock_ok rises on the LOCK_FILT_CYC-th consecutive synced 1 and drops on the first synced 0.
module rst_lock_filt
  import eth_rst_pkg::*;
#(
  parameter int unsigned LOCK_FILT_CYC = 16
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic pll_locked,
  output logic lock_ok
);

  localparam int unsigned FILT_N = eff_cyc(LOCK_FILT_CYC);
  localparam int FILT_W = cnt_width(FILT_N);
  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILT_N - 32'd1);

  logic              sync1;
  logic              sync2;
  logic [FILT_W-1:0] filt_cnt;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      filt_cnt <= '0;
      lock_ok  <= 1'b0;
    end else begin
      sync1 <= pll_locked;
      sync2 <= sync1;
      if (!sync2) begin
        filt_cnt <= '0;
        lock_ok  <= 1'b0;
      end else begin
        // filt_cnt holds (samples seen - 1) and parks at FILT_LAST once qualified
        if (filt_cnt != FILT_LAST) filt_cnt <= filt_cnt + FILT_W'(1);
        if (filt_cnt == FILT_LAST) lock_ok <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/eth_rst_seq.sv
// Ethernet system reset sequencer: qualified PLL lock, timed PHY reset, staggered domain release.
// Optional watchdog re-sequence is compiled in with ETH_RST_SEQ_WDT_EN.
//
// state      | meaning
// WAIT_LOCK  | all resets asserted, waiting for qualified lock
// PHY_RST    | eth_rst_n held low for PHY_RST_CYC clocks
// PHY_SETTLE | PHY released, waiting PHY_SETTLE_CYC before first domain
// RELEASE    | domains released one per STAGE_GAP_CYC, index 0 first
// RUN        | everything out of reset, seq_done=1
module eth_rst_seq
  import eth_rst_pkg::*;
#(
  parameter int          N_OUT          = 3,
  parameter int unsigned LOCK_FILT_CYC  = 16,
  parameter int unsigned PHY_RST_CYC    = 1000000,
  parameter int unsigned PHY_SETTLE_CYC = 5000,
  parameter int unsigned STAGE_GAP_CYC  = 256,
  parameter int unsigned WDT_CYC        = 2**24
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             pll_locked,
  input  logic             sw_rst_req,
  input  logic             wdt_kick,
  output logic             eth_rst_n,
  output logic [N_OUT-1:0] rst_n_out,
  output logic             seq_done,
  output logic             wdt_fired
);

  localparam int unsigned MAX_CYC = max_cyc(LOCK_FILT_CYC, PHY_RST_CYC, PHY_SETTLE_CYC,
                                            STAGE_GAP_CYC, WDT_CYC);
  localparam int CNT_W = cnt_width(MAX_CYC);
  localparam int IDX_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  localparam logic [CNT_W-1:0] PHY_RST_LD = CNT_W'(eff_cyc(PHY_RST_CYC) - 32'd1);
  localparam logic [CNT_W-1:0] SETTLE_LD  = CNT_W'(eff_cyc(PHY_SETTLE_CYC) - 32'd1);
  localparam logic [CNT_W-1:0] GAP_LD     = CNT_W'(eff_cyc(STAGE_GAP_CYC) - 32'd1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_OUT - 1);
  localparam logic [N_OUT-1:0] OUT_LSB    = N_OUT'(1);

  rst_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic             lock_ok;
  logic             wdt_hit;

  rst_lock_filt #(
    .LOCK_FILT_CYC(LOCK_FILT_CYC)
  ) u_lock_filt (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .pll_locked(pll_locked),
    .lock_ok   (lock_ok)
  );

  // Only WAIT_LOCK is entered without lock_ok, so !lock_ok elsewhere is always a lock loss.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= WAIT_LOCK;
      cnt       <= '0;
      idx       <= '0;
      eth_rst_n <= 1'b0;
      rst_n_out <= '0;
      seq_done  <= 1'b0;
    end else if (state != WAIT_LOCK && !lock_ok) begin
      state     <= WAIT_LOCK;
      cnt       <= '0;
      idx       <= '0;
      eth_rst_n <= 1'b0;
      rst_n_out <= '0;
      seq_done  <= 1'b0;
    end else if (sw_rst_req && (state == RELEASE || state == RUN)) begin
      state     <= PHY_SETTLE;
      cnt       <= SETTLE_LD;
      idx       <= '0;
      rst_n_out <= '0;
      seq_done  <= 1'b0;
    end else if (wdt_hit) begin
      state     <= PHY_RST;
      cnt       <= PHY_RST_LD;
      idx       <= '0;
      eth_rst_n <= 1'b0;
      rst_n_out <= '0;
      seq_done  <= 1'b0;
    end else begin
      case (state)
        WAIT_LOCK: begin
          if (lock_ok) begin
            state <= PHY_RST;
            cnt   <= PHY_RST_LD;
          end
        end
        PHY_RST: begin
          if (cnt == '0) begin
            eth_rst_n <= 1'b1;
            state     <= PHY_SETTLE;
            cnt       <= SETTLE_LD;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        // Domain 0 is released on the last settle clock; idx then names the next domain.
        PHY_SETTLE: begin
          if (cnt == '0) begin
            rst_n_out <= OUT_LSB;
            if (N_OUT == 1) begin
              state    <= RUN;
              seq_done <= 1'b1;
            end else begin
              state <= RELEASE;
              idx   <= IDX_W'(1);
              cnt   <= GAP_LD;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RELEASE: begin
          if (cnt == '0) begin
            rst_n_out <= (rst_n_out << 1) | OUT_LSB;
            if (idx == IDX_LAST) begin
              state    <= RUN;
              seq_done <= 1'b1;
            end else begin
              idx <= idx + IDX_W'(1);
              cnt <= GAP_LD;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RUN: begin
          seq_done <= 1'b1;
        end
        default: begin
          state     <= WAIT_LOCK;
          eth_rst_n <= 1'b0;
          rst_n_out <= '0;
          seq_done  <= 1'b0;
        end
      endcase
    end
  end

`ifdef ETH_RST_SEQ_WDT_EN
  localparam int WDT_W = cnt_width(eff_cyc(WDT_CYC));
  localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(eff_cyc(WDT_CYC) - 32'd1);

  logic [WDT_W-1:0] wdt_cnt;

  // Lock loss and software requests take precedence over a watchdog expiry.
  assign wdt_hit = (state == RUN) && lock_ok && !sw_rst_req && !wdt_kick && (wdt_cnt == WDT_LAST);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wdt_cnt   <= '0;
      wdt_fired <= 1'b0;
    end else begin
      if (state != RUN || wdt_kick || wdt_hit) wdt_cnt <= '0;
      else                                    wdt_cnt <= wdt_cnt + WDT_W'(1);
      if (sw_rst_req)   wdt_fired <= 1'b0;
      else if (wdt_hit) wdt_fired <= 1'b1;
    end
  end
`else
  logic unused_wdt_kick;
  assign unused_wdt_kick = wdt_kick;
  assign wdt_hit         = 1'b0;
  assign wdt_fired       = 1'b0;
`endif

endmodule

// File: tb/tb_eth_rst_seq.sv
// Self-checking bench for eth_rst_seq: timestamp-based reference model plus directed timeline checks.
// Define ETH_RST_SEQ_WDT_EN for both DUT and bench to exercise the watchdog path.
module tb_eth_rst_seq;

  localparam int N    = 3;
  localparam int LF   = 4;
  localparam int PRC  = 20;
  localparam int SC   = 10;
  localparam int GAP  = 5;
  localparam int WDT  = 50;

  logic         sys_clk;
  logic         sys_rst_n;
  logic         pll_locked;
  logic         sw_rst_req;
  logic         wdt_kick;
  logic         eth_rst_n;
  logic [N-1:0] rst_n_out;
  logic         seq_done;
  logic         wdt_fired;

  int n_chk  = 0;
  int n_fail = 0;

  eth_rst_seq #(
    .N_OUT(N), .LOCK_FILT_CYC(LF), .PHY_RST_CYC(PRC), .PHY_SETTLE_CYC(SC),
    .STAGE_GAP_CYC(GAP), .WDT_CYC(WDT)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .pll_locked(pll_locked),
    .sw_rst_req(sw_rst_req), .wdt_kick(wdt_kick), .eth_rst_n(eth_rst_n),
    .rst_n_out(rst_n_out), .seq_done(seq_done), .wdt_fired(wdt_fired)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  // Reference model: the whole sequence is a timeline anchored at t_set (edge index where the
  // PHY comes out of reset); outputs are plain comparisons of the edge index against it.
  int   cyc_m     = 0;
  int   t_set     = 0;
  int   last_kick = 0;
  bit   active    = 1'b0;
  bit   lk_prev   = 1'b0;
  bit   m_wdt     = 1'b0;
  bit   hist[$];
  logic         e_eth  = 1'b0;
  logic [N-1:0] e_out  = '0;
  logic         e_done = 1'b0;

  always @(posedge sys_clk or negedge sys_rst_n) begin
    int  k;
    int  run_at;
    bit  in_run;
    bit  fire;
    bit  lk_now;
    if (!sys_rst_n) begin
      hist.delete();
      cyc_m = 0; t_set = 0; last_kick = 0;
      active = 1'b0; lk_prev = 1'b0; m_wdt = 1'b0;
      e_eth = 1'b0; e_out = '0; e_done = 1'b0;
    end else begin
      k = cyc_m + 1;
      cyc_m = k;
      run_at = t_set + SC + (N - 1) * GAP;
      in_run = active && (k > run_at);
      fire = 1'b0;
`ifdef ETH_RST_SEQ_WDT_EN
      if (in_run && lk_prev && !sw_rst_req && !wdt_kick &&
          (k - ((last_kick > run_at) ? last_kick : run_at) == WDT)) fire = 1'b1;
      if (in_run && wdt_kick) last_kick = k;
      if (sw_rst_req) m_wdt = 1'b0;
      else if (fire)  m_wdt = 1'b1;
`endif
      if (!active) begin
        if (lk_prev) begin
          active = 1'b1;
          t_set  = k + PRC;
        end
      end else if (!lk_prev) begin
        active = 1'b0;
      end else if (sw_rst_req && (k > t_set + SC)) begin
        t_set = k;
      end else if (fire) begin
        t_set = k + PRC;
      end
      // lock_ok after edge k = the LF samples taken at edges k-LF-1 .. k-2 were all 1
      hist.push_back(pll_locked);
      if (hist.size() > 32) void'(hist.pop_front());
      lk_now = (hist.size() >= LF + 2);
      if (lk_now)
        for (int j = 0; j < LF; j++)
          if (!hist[hist.size() - 3 - j]) lk_now = 1'b0;
      e_eth = active && (k >= t_set);
      for (int i = 0; i < N; i++) e_out[i] = active && (k >= t_set + SC + i * GAP);
      e_done = active && (k >= t_set + SC + (N - 1) * GAP);
      lk_prev = lk_now;
    end
  end

  always @(negedge sys_clk) begin
    if (sys_rst_n === 1'b1) begin
      chk("cyc_eth_rst_n", 8'(eth_rst_n), 8'(e_eth));
      chk("cyc_rst_n_out", 8'(rst_n_out), 8'(e_out));
      chk("cyc_seq_done",  8'(seq_done),  8'(e_done));
      chk("cyc_wdt_fired", 8'(wdt_fired), 8'(m_wdt));
    end
  end

  // Directed power-up timeline from the negedge pll_locked is raised.
  task automatic seq_from_lock(input string tag);
    pll_locked = 1'b1;
    step(26);
    chk({tag, "_eth_lo"}, 8'(eth_rst_n), 8'h00);
    step(1);
    chk({tag, "_eth_hi"}, 8'(eth_rst_n), 8'h01);
    chk({tag, "_model_eth"}, 8'(e_eth), 8'h01);
    step(9);
    chk({tag, "_out_pre"}, 8'(rst_n_out), 8'h00);
    step(1);
    chk({tag, "_out0"}, 8'(rst_n_out), 8'h01);
    step(5);
    chk({tag, "_out1"}, 8'(rst_n_out), 8'h03);
    chk({tag, "_done_lo"}, 8'(seq_done), 8'h00);
    step(5);
    chk({tag, "_out2"}, 8'(rst_n_out), 8'h07);
    chk({tag, "_done_hi"}, 8'(seq_done), 8'h01);
    chk({tag, "_model_done"}, 8'(e_done), 8'h01);
  endtask

  int drop_left;

  initial begin
    sys_rst_n  = 1'b1;
    pll_locked = 1'b0;
    sw_rst_req = 1'b0;
    wdt_kick   = 1'b0;
    #1 sys_rst_n = 1'b0;
    #22;
    chk("rst_eth", 8'(eth_rst_n), 8'h00);
    chk("rst_out", 8'(rst_n_out), 8'h00);
    chk("rst_done", 8'(seq_done), 8'h00);
    chk("rst_wdt", 8'(wdt_fired), 8'h00);
    @(negedge sys_clk);
    #1 sys_rst_n = 1'b1;
    step(2);

    // glitchy lock never qualifies
    repeat (12) begin
      pll_locked = 1'b1; step(3);
      pll_locked = 1'b0; step(1);
    end
    chk("glitch_eth", 8'(eth_rst_n), 8'h00);
    chk("glitch_out", 8'(rst_n_out), 8'h00);
    step(4);

    seq_from_lock("pwrup");
    step(7);

    // software re-sequence from RUN: PHY untouched, domains replay from settle
    sw_rst_req = 1'b1;
    step(1);
    sw_rst_req = 1'b0;
    chk("sw_out_clr", 8'(rst_n_out), 8'h00);
    chk("sw_eth_hold", 8'(eth_rst_n), 8'h01);
    chk("sw_done_clr", 8'(seq_done), 8'h00);
    step(9);
    chk("sw_out_pre", 8'(rst_n_out), 8'h00);
    step(1);
    chk("sw_out0", 8'(rst_n_out), 8'h01);
    step(5);
    chk("sw_out1", 8'(rst_n_out), 8'h03);
    step(5);
    chk("sw_out2", 8'(rst_n_out), 8'h07);
    chk("sw_done", 8'(seq_done), 8'h01);
    step(3);

    // lock loss in RUN
    pll_locked = 1'b0;
    step(3);
    chk("loss_eth_still", 8'(eth_rst_n), 8'h01);
    step(1);
    chk("loss_eth", 8'(eth_rst_n), 8'h00);
    chk("loss_out", 8'(rst_n_out), 8'h00);
    chk("loss_done", 8'(seq_done), 8'h00);
    seq_from_lock("relock");

    // async reset mid-RELEASE
    pll_locked = 1'b0;
    step(4);
    pll_locked = 1'b1;
    step(38);
    chk("mid_out", 8'(rst_n_out), 8'h01);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("async_eth", 8'(eth_rst_n), 8'h00);
    chk("async_out", 8'(rst_n_out), 8'h00);
    chk("async_done", 8'(seq_done), 8'h00);
    step(2);
    #1 sys_rst_n = 1'b1;
    step(60);
    chk("rerun_done", 8'(seq_done), 8'h01);

`ifdef ETH_RST_SEQ_WDT_EN
    repeat (5) begin
      wdt_kick = 1'b1; step(1);
      wdt_kick = 1'b0; step(39);
    end
    chk("wdt_kicked_quiet", 8'(wdt_fired), 8'h00);
    chk("wdt_kicked_done", 8'(seq_done), 8'h01);
    wdt_kick = 1'b1; step(1);
    wdt_kick = 1'b0;
    step(49);
    chk("wdt_pre_fire", 8'(wdt_fired), 8'h00);
    chk("wdt_pre_eth", 8'(eth_rst_n), 8'h01);
    step(1);
    chk("wdt_fire", 8'(wdt_fired), 8'h01);
    chk("wdt_fire_eth", 8'(eth_rst_n), 8'h00);
    chk("wdt_fire_out", 8'(rst_n_out), 8'h00);
    step(19);
    chk("wdt_phy_lo", 8'(eth_rst_n), 8'h00);
    step(1);
    chk("wdt_phy_hi", 8'(eth_rst_n), 8'h01);
    sw_rst_req = 1'b1; step(1);
    sw_rst_req = 1'b0;
    chk("wdt_sw_clear", 8'(wdt_fired), 8'h00);
    step(40);
`endif

    // randomized traffic against the model
    drop_left = 0;
    for (int c = 0; c < 3000; c++) begin
      if (drop_left > 0) begin
        pll_locked = 1'b0;
        drop_left--;
      end else begin
        pll_locked = 1'b1;
        if ($urandom_range(0, 249) == 0) drop_left = $urandom_range(1, 8);
      end
      sw_rst_req = ($urandom_range(0, 79) == 0);
      wdt_kick   = ($urandom_range(0, 24) == 0);
      step(1);
    end
    sw_rst_req = 1'b0;
    wdt_kick   = 1'b0;
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
